seg_scan_capture: RTL

//   Reader side of the multiplexed 7-segment display bus. Samples active-low segment and anode

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_scan_capture_if.sv | 28 ++
 rtl/seg_pattern_decode.sv | 33 +++
 rtl/seg_scan_capture.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment bus, used by both the segment encoder
// and the scan reader. Segment patterns are {g,f,e,d,c,b,a}, active low.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hE;
  localparam logic [3:0] CODE_ERR   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg_scan_capture_if.sv
// Display bus as seen by the scan reader: panel-driven lines plus the captured results.
// master = panel/test side, slave = capture block.
interface seg_scan_capture_if #(
  parameter int NUM_DIGITS = 4,
  parameter int ERR_W      = 8
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    update_pulse;
  logic [IDX_W-1:0]        update_idx;
  logic                    err_pulse;
  logic [ERR_W-1:0]        err_count;

  modport master (
    output seg_n, an_n, clear,
    input  digits, digit_valid, update_pulse, update_idx, err_pulse, err_count
  );

  modport slave (
    input  seg_n, an_n, clear,
    output digits, digit_valid, update_pulse, update_idx, err_pulse, err_count
  );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational decode of an active-low segment pattern back to its BCD code.
// Blank maps to CODE_BLANK, anything not in the legal table maps to CODE_ERR.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] code,
  output logic       is_digit,
  output logic       is_err
);

  // Pattern lookup plus classification flags
  always_comb begin
    code = CODE_ERR;
    case (seg_n)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   code = CODE_ERR;
    endcase
    is_digit = (code <= 4'd9);
    is_err   = (code == CODE_ERR);
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Reader side of the multiplexed 7-segment bus: synchronizes anode/segment lines, waits for
// a stable one-hot pattern, decodes it and stores the code in the selected position.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_scan_capture_if.slave   bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SMP_W = NUM_DIGITS + 7;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SMP_W-1:0]        sync1_r;
  logic [SMP_W-1:0]        sync2_r;
  logic [SMP_W-1:0]        ref_r;
  seg_state_e              state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [4*NUM_DIGITS-1:0] digits_r;
  logic [NUM_DIGITS-1:0]   digit_valid_r;
  logic                    update_pulse_r;
  logic [IDX_W-1:0]        update_idx_r;
  logic                    err_pulse_r;
  logic [ERR_W-1:0]        err_count_r;

  logic [NUM_DIGITS-1:0]   an_s;
  logic [6:0]              seg_s;
  int unsigned             zero_cnt_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    s_valid_s;
  logic                    s_match_s;
  logic                    load_s;
  logic                    capture_s;
  logic [3:0]              code_s;
  logic                    is_digit_s;
  logic                    is_err_s;

  // Two-flop synchronizer; idles high so a reset bus looks unselected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= '1;
      sync2_r <= '1;
    end else begin
      sync1_r <= {bus.an_n, bus.seg_n};
      sync2_r <= sync1_r;
    end
  end

  // One-hot check on the anodes and capture/restart decisions for this sample
  always_comb begin
    an_s       = sync2_r[SMP_W-1:7];
    seg_s      = sync2_r[6:0];
    zero_cnt_s = 32'd0;
    idx_s      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_cnt_s = zero_cnt_s + 32'(!an_s[i]);
      idx_s      = an_s[i] ? idx_s : IDX_W'(i);
    end
    s_valid_s = (zero_cnt_s == 32'd1);
    s_match_s = (sync2_r == ref_r);
    load_s    = s_valid_s && ((state_r == ST_IDLE) || !s_match_s);
    // A single-cycle stability requirement captures on the very sample that starts a run
    capture_s = s_valid_s &&
                ((load_s && (STABLE_CYCLES == 1)) ||
                 ((state_r == ST_SETTLE) && s_match_s && (cnt_r >= CNT_LAST)));
  end

  seg_pattern_decode u_decode (
    .seg_n    (seg_s),
    .code     (code_s),
    .is_digit (is_digit_s),
    .is_err   (is_err_s)
  );

  // Stability FSM and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      ref_r          <= '1;
      digits_r       <= '0;
      digit_valid_r  <= '0;
      update_pulse_r <= 1'b0;
      update_idx_r   <= '0;
      err_pulse_r    <= 1'b0;
      err_count_r    <= '0;
    end else if (bus.clear) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      digits_r       <= '0;
      digit_valid_r  <= '0;
      update_pulse_r <= 1'b0;
      err_pulse_r    <= 1'b0;
      err_count_r    <= '0;
    end else begin
      update_pulse_r <= 1'b0;
      err_pulse_r    <= 1'b0;
      if (!s_valid_s) begin
        state_r <= ST_IDLE;
        cnt_r   <= '0;
      end else if (capture_s) begin
        state_r                           <= ST_HELD;
        cnt_r                             <= CNT_MAX;
        ref_r                             <= sync2_r;
        digits_r[{idx_s, 2'b00} +: 4]     <= code_s;
        digit_valid_r[idx_s]              <= is_digit_s;
        update_pulse_r                    <= 1'b1;
        update_idx_r                      <= idx_s;
        if (is_err_s) begin
          err_pulse_r <= 1'b1;
          err_count_r <= (err_count_r == {ERR_W{1'b1}}) ? err_count_r
                                                        : err_count_r + ERR_W'(1);
        end else begin
          err_pulse_r <= 1'b0;
        end
      end else if (load_s) begin
        state_r <= ST_SETTLE;
        ref_r   <= sync2_r;
        cnt_r   <= CNT_ONE;
      end else if (state_r == ST_SETTLE) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign bus.digits       = digits_r;
  assign bus.digit_valid  = digit_valid_r;
  assign bus.update_pulse = update_pulse_r;
  assign bus.update_idx   = update_idx_r;
  assign bus.err_pulse    = err_pulse_r;
  assign bus.err_count    = err_count_r;

endmodule
